// File: rtl/booth_mul_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
// Digit codes are packed as {neg, two, zero}.
package booth_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] ZERO = 3'b001;
   localparam logic [2:0] POS1 = 3'b000;
   localparam logic [2:0] POS2 = 3'b010;
   localparam logic [2:0] NEG1 = 3'b100;
   localparam logic [2:0] NEG2 = 3'b110;

   function automatic int iter_count(input int w);
      return w / 2 + 1;
   endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth recoder: 3-bit multiplier window to {neg, two, zero}.
module booth_r4_recode
   import booth_mul_pkg::*;
(
   input  logic [2:0] win,
   output logic       neg,
   output logic       two,
   output logic       zero
);

   logic [2:0] dig;

   always_comb begin
      dig = ZERO;
      unique case (win)
         3'b001, 3'b010: dig = POS1;
         3'b011:         dig = POS2;
         3'b100:         dig = NEG2;
         3'b101, 3'b110: dig = NEG1;
         default:        dig = ZERO;
      endcase
   end

   assign {neg, two, zero} = dig;

endmodule

// File: rtl/booth_r4_mul_pipe_ctl.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes.
// Optional BOOTH_MUL_ZERO_SKIP_EN bypasses CALC for zero operands.
module booth_r4_mul_pipe_ctl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH/2+2)
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_signed,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] Product,
   output logic               busy
);
   import booth_mul_pkg::*;

   localparam int W2 = WIDTH + 2;
   localparam int PW = W2 + 1;
   localparam int AW = 2 * W2 + 2;
   localparam int NIT = iter_count(WIDTH);

   if (WIDTH < 4 || WIDTH % 2 != 0) begin : g_bad_width
      $error("booth_r4_mul_pipe_ctl: WIDTH must be even and >= 4");
   end

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [AW-1:0]      acc_q;
   logic [W2-1:0]      ea_q;
   logic [2*WIDTH-1:0] prod_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;

   logic [W2-1:0] ext_a;
   logic [W2-1:0] ext_b;
   logic          skip;

   assign ext_a = in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
   assign ext_b = in_signed ? {{2{in_b[WIDTH-1]}}, in_b} : {2'b00, in_b};

`ifdef BOOTH_MUL_ZERO_SKIP_EN
   assign skip = (in_a == '0) || (in_b == '0);
`else
   assign skip = 1'b0;
`endif

   logic neg;
   logic two;
   logic zero;

   booth_r4_recode u_rec (
      .win  (acc_q[2:0]),
      .neg  (neg),
      .two  (two),
      .zero (zero)
   );

   logic [PW-1:0]        pp_mag;
   logic [PW-1:0]        pp;
   logic [PW-1:0]        sum;
   logic signed [AW-1:0] acc_add;
   logic [AW-1:0]        acc_sh;

   // Upper field is one bit wider than ext_a so +/-2*a never overflows.
   always_comb begin
      pp_mag  = two ? {ea_q, 1'b0} : {ea_q[W2-1], ea_q};
      pp      = zero ? '0 : (neg ? (~pp_mag + PW'(1)) : pp_mag);
      sum     = acc_q[AW-1:W2+1] + pp;
      acc_add = {sum, acc_q[W2:0]};
      acc_sh  = acc_add >>> 2;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         ea_q        <= '0;
         prod_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  cnt_q      <= '0;
                  if (skip) begin
                     prod_q      <= '0;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     ea_q    <= ext_a;
                     acc_q   <= {{PW{1'b0}}, ext_b, 1'b0};
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               acc_q <= acc_sh;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(NIT - 1)) begin
                  prod_q      <= acc_sh[2*WIDTH:1];
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign Product   = prod_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_booth_r4_mul_pipe_ctl.sv
// Directed and random checks of booth_r4_mul_pipe_ctl against an
// arithmetic reference (plain signed/unsigned multiply).
module tb_booth_r4_mul_pipe_ctl;

   localparam int W = 8;

   logic           CLK;
   logic           RST_N;
   logic           in_valid;
   logic           in_ready;
   logic           in_signed;
   logic [W-1:0]   in_a;
   logic [W-1:0]   in_b;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] Product;
   logic           busy;

   int total;
   int bad;

   booth_r4_mul_pipe_ctl #(.WIDTH(W)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_signed (in_signed),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Product   (Product),
      .busy      (busy)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic s);
      longint sa;
      longint sb;
      longint p;
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      p  = sa * sb;
      return p[2*W-1:0];
   endfunction

   function automatic int ref_lat(input logic [W-1:0] a,
                                  input logic [W-1:0] b);
`ifdef BOOTH_MUL_ZERO_SKIP_EN
      if (a == '0 || b == '0) return 1;
`endif
      return W / 2 + 2;
   endfunction

   // Called at a negedge; returns at a negedge back in IDLE.
   task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input int hold,
                          input string tag);
      logic [2*W-1:0] exp_p;
      int             lat;
      exp_p = ref_mul(a, b, s);
      lat   = 0;
      while (!in_ready && lat < 50) begin
         @(negedge CLK);
         lat++;
      end
      check({tag, "_rdy"}, 64'(in_ready), 64'(1));
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_signed = s;
      @(negedge CLK);
      in_valid  = 1'b0;
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_signed = 1'($urandom);
      check({tag, "_busy"}, {62'd0, in_ready, busy}, 64'b01);
      lat = 1;
      while (!out_valid && lat < 50) begin
         @(negedge CLK);
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'(ref_lat(a, b)));
      check({tag, "_prod"}, 64'(Product), 64'(exp_p));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         in_a     = W'($urandom);
         in_b     = W'($urandom);
         @(negedge CLK);
         check({tag, "_hold"}, {61'd0, out_valid, in_ready, busy}, 64'b101);
         check({tag, "_hprod"}, 64'(Product), 64'(exp_p));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge CLK);
      out_ready = 1'b0;
      check({tag, "_idle"}, {61'd0, out_valid, in_ready, busy}, 64'b010);
      check({tag, "_keep"}, 64'(Product), 64'(exp_p));
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      total     = 0;
      bad       = 0;
      RST_N     = 1'b0;
      in_valid  = 1'b0;
      in_signed = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      check("reset_ctl", {61'd0, out_valid, in_ready, busy}, 64'b010);
      check("reset_prod", 64'(Product), 64'(0));

      run_txn(8'hF9, 8'h0D, 1'b1, 0, "s_m7x13");
      run_txn(8'hFF, 8'hFF, 1'b0, 0, "u_ffxff");
      run_txn(8'hFF, 8'hFF, 1'b1, 0, "s_ffxff");
      run_txn(8'h80, 8'h80, 1'b1, 0, "s_minxmin");
      run_txn(8'h80, 8'h7F, 1'b1, 0, "s_minxmax");
      run_txn(8'h80, 8'h80, 1'b0, 0, "u_80x80");
      run_txn(8'h5C, 8'hA7, 1'b1, 5, "backpress");
      run_txn(8'h00, 8'h5A, 1'b0, 0, "zero_a");
      run_txn(8'h33, 8'h00, 1'b1, 0, "zero_b");

      // Abort mid-CALC with an asynchronous reset.
      in_valid  = 1'b1;
      in_a      = 8'h7B;
      in_b      = 8'h6D;
      in_signed = 1'b0;
      @(negedge CLK);
      in_valid = 1'b0;
      @(negedge CLK);
      #2 RST_N = 1'b0;
      #1;
      check("abort_ctl", {62'd0, out_valid, busy}, 64'b00);
      check("abort_prod", 64'(Product), 64'(0));
      @(negedge CLK);
      RST_N = 1'b1;
      for (int i = 0; i < 8; i++) @(negedge CLK);
      check("abort_quiet", {61'd0, out_valid, in_ready, busy}, 64'b010);
      run_txn(8'd3, 8'd5, 1'b0, 0, "after_rst");

      for (int n = 0; n < 1000; n++) begin
         ra = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
         rb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
         run_txn(ra, rb, 1'($urandom), int'($urandom_range(0, 2)), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
